spi_flash_resp: RTL and testbench
=================================

# spi_flash_resp

Synthesizable SPI flash responder (mode 0) that answers the same command set our flash controllers issue: WREN, WRDI, RDSR, READ, PP and BE. It sits on the far end of sck/cs_n/mosi from a controller such as the bulk-erase or page-program masters. It runs from the system clock by oversampling the SPI pins. The backing store is a small on-chip array, which makes the block usable as an on-board loopback target and as a synthesizable bench slave.

## Interface
- MEM_AW, 8: address width of internal memory; depth 2^MEM_AW bytes; SPI address uses low MEM_AW bits.
- ERASE_CYCLES, 1000: sys_clk cycles WIP stays high after BE; must be ≥ 2^MEM_AW.
- PROG_CYCLES, 50: sys_clk cycles WIP stays high after PP.

- sys_clk  in  1  system clock; all logic on rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- sck  in  1  SPI clock, asynchronous to sys_clk.
- cs_n  in  1  chip select, active low.
- mosi  in  1  serial data in, MSB first.
- miso  out  1  serial data out, MSB first; 0 when not shifting data.
- wip  out  1  status bit0, write in progress.
- wel  out  1  status bit1, write enable latch.

## Operation
- sck, cs_n and mosi each pass through a 2-flop synchronizer. Edge detect runs on the synchronized sck and cs_n.
- mosi is sampled on sck rise. miso is updated on sck fall. The first output bit is driven on the sck fall after the last command/address bit.
- FSM states: IDLE, CMD, ADDR, DIN, DOUT, IGNORE.
  - cs_n fall: IDLE → CMD, bit counter = 0.
  - cs_n rise in any state: → IDLE, then a command that is pending at a byte boundary executes.
- CMD decodes the 8th bit:
  - 0x06 WREN and 0x04 WRDI: wait for cs_n rise. The command executes only if cs_n rises with bit count 0 mod 8; WREN sets wel, WRDI clears wel.
  - 0x05 RDSR: → DOUT. Streams {6'b0, wel, wip}, repeated, with live values.
  - 0x03 READ: → ADDR (24 bits) → DOUT. Streams mem[addr]. The address increments after each byte and wraps at 2^MEM_AW.
  - 0x02 PP: requires wel=1. → ADDR → DIN. Each complete byte b does mem[addr] ← mem[addr] & b (bits go 1→0 only). The address increments and wraps at 2^MEM_AW. Partial trailing bits are discarded.
    - On cs_n rise after ≥1 complete data byte: wip=1 for PROG_CYCLES and wel cleared.
    - On cs_n rise with 0 data bytes: no effect, and wel is unchanged.
  - 0xC7 BE: requires wel=1. Executes on cs_n rise at a byte boundary. Sets wip=1 for ERASE_CYCLES and clears wel. During the busy period an erase counter writes 0xFF to mem[0..2^MEM_AW-1], one byte per cycle.
  - Any other opcode, a PP/BE without wel, or any opcode other than RDSR while wip=1: → IGNORE until cs_n rise.
- Reset clears the FSM to IDLE, wel=0, wip=0, the busy timer, the erase counter and miso=0. Memory contents are not reset. An erase cut off by reset leaves memory partially erased.

## Timing
- The synchronizer plus edge detect gives 3 sys_clk cycles of delay from a pin edge to the internal action.
- The sck high and low half-periods must each be ≥ 4 sys_clk.
- cs_n setup and hold to sck edges must be ≥ 4 sys_clk.
- miso changes 3 sys_clk after sck fall, which is valid before the next sck rise under the constraint above.
- wip rises 4 sys_clk after the cs_n rise, stays high for exactly PROG_CYCLES or ERASE_CYCLES cycles, then falls.
- wel updates in the same cycle that wip rises.
- If RDSR is running when wip falls, the next byte boundary shows the new value. The value never changes mid-byte: status is latched at each byte start.
- The READ data byte is fetched from memory at the last address bit. A 1-cycle read latency is absorbed before the first sck fall.

## Configuration
- FLASH_RESP_RDID_EN defined: opcode 0x9F (RDID) → DOUT. It streams 0x20, 0x20, 0x15 and then repeats 0x15. It is rejected while wip=1.
- Not defined: 0x9F is treated as an unknown opcode and goes to IGNORE.

## Test plan
- Reset, then RDSR → miso bytes 0x00; wel=0, wip=0.
- WREN (cs_n high after 8 bits), then RDSR → 0x02. WREN with 7 bits then cs_n high → wel stays 0.
- BE without WREN → wip stays 0. WREN then BE → wip=1 for 1000 cycles, wel=0; RDSR during busy shows 0x01 then 0x00; READ at 0x000000 returns 0xFF ×256 and wraps to addr 0.
- After erase: WREN, PP at 0x0000FE with data 0xA5, 0x3C, 0x81 → bytes written at 0xFE, 0xFF, 0x00 (wrap). READ from 0x0000FE returns 0xA5, 0x3C, 0x81. A second PP of 0xF0 to 0xFE then reads back 0xA0.
- READ issued while wip=1 → miso stays 0 and the FSM ignores the command until cs_n rises. Assert sys_rst mid-erase → wip=0, wel=0, FSM in IDLE on the next cycle.
- With FLASH_RESP_RDID_EN: 0x9F → 0x20, 0x20, 0x15. Without it: miso stays 0.

Source files
------------

// File: rtl/spi_flash_resp_if.sv
// SPI mode-0 pin bundle between a flash controller (master) and the flash responder (slave).
interface spi_flash_resp_if;
   logic sck;
   logic cs_n;
   logic mosi;
   logic miso;

   modport master (output sck, output cs_n, output mosi, input miso);
   modport slave  (input sck, input cs_n, input mosi, output miso);
endinterface

// File: rtl/spi_flash_resp.sv
// Oversampled SPI mode-0 flash responder (WREN/WRDI/RDSR/READ/PP/BE) backed by an on-chip byte array.
// Define FLASH_RESP_RDID_EN to answer RDID (0x9F) with 0x20, 0x20, 0x15, 0x15, ...
//
// state  | meaning
// IDLE   | cs_n high, waiting for cs_n fall
// CMD    | shifting opcode; afterwards holds a pending WREN/WRDI/BE until cs_n rise
// ADDR   | shifting 24 address bits for READ/PP
// DIN    | PP data bytes, AND-programmed into memory
// DOUT   | streaming status, memory or ID bytes on miso
// IGNORE | rejected command, waiting for cs_n rise
module spi_flash_resp #(
   parameter int MEM_AW       = 8,
   parameter int ERASE_CYCLES = 1000,
   parameter int PROG_CYCLES  = 50
) (
   input  logic            sys_clk,
   input  logic            sys_rst,
   spi_flash_resp_if.slave spi,
   output logic            wip,
   output logic            wel
);
   localparam int BUSY_MAX = (ERASE_CYCLES > PROG_CYCLES) ? ERASE_CYCLES : PROG_CYCLES;
   localparam int BUSY_W   = $clog2(BUSY_MAX + 1);

   typedef enum logic [2:0] {IDLE, CMD, ADDR, DIN, DOUT, IGNORE} state_t;
   typedef enum logic [2:0] {OP_NONE, OP_WREN, OP_WRDI, OP_BE, OP_PP, OP_READ, OP_RDSR, OP_RDID} op_t;

   state_t state, state_nxt;
   op_t    op, op_dec, exec_op, exec_nxt;

   logic [2:0]        sck_sy, cs_sy;
   logic [1:0]        mosi_sy;
   logic              sck_rise, sck_fall, cs_rise, cs_fall, mosi_s;
   logic [4:0]        bit_cnt;
   logic [6:0]        shift_in;
   logic [7:0]        shift_out, out_byte, cmd_byte, mem_rdata;
   logic [MEM_AW-1:0] addr, erase_addr;
   logic [1:0]        id_idx;
   logic              pp_any, pp_wr, decode_now, miso_q, erase_active;
   logic [BUSY_W-1:0] busy_cnt;
   logic [7:0]        mem [0:(1<<MEM_AW)-1];

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         sck_sy  <= '0;
         cs_sy   <= '1;
         mosi_sy <= '0;
      end else begin
         sck_sy  <= {sck_sy[1:0], spi.sck};
         cs_sy   <= {cs_sy[1:0], spi.cs_n};
         mosi_sy <= {mosi_sy[0], spi.mosi};
      end
   end

   assign sck_rise = sck_sy[1] & ~sck_sy[2];
   assign sck_fall = ~sck_sy[1] & sck_sy[2];
   assign cs_rise  = cs_sy[1] & ~cs_sy[2];
   assign cs_fall  = ~cs_sy[1] & cs_sy[2];
   assign mosi_s   = mosi_sy[1];
   assign cmd_byte = {shift_in, mosi_s};
   assign wip      = (busy_cnt != '0);
   assign spi.miso = miso_q;

   assign decode_now = (state == CMD) && sck_rise && (op == OP_NONE) && (bit_cnt == 5'd7);
   assign pp_wr      = (state == DIN) && sck_rise && (bit_cnt[2:0] == 3'd7);

   // Only RDSR is honoured while a program/erase is in flight.
   always_comb begin
      op_dec = OP_NONE;
      case (cmd_byte)
         8'h05: op_dec = OP_RDSR;
         8'h03: if (!wip) op_dec = OP_READ;
         8'h02: if (!wip && wel) op_dec = OP_PP;
         8'h06: if (!wip) op_dec = OP_WREN;
         8'h04: if (!wip) op_dec = OP_WRDI;
         8'hC7: if (!wip && wel) op_dec = OP_BE;
`ifdef FLASH_RESP_RDID_EN
         8'h9F: if (!wip) op_dec = OP_RDID;
`endif
         default: op_dec = OP_NONE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (cs_rise) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: if (cs_fall) state_nxt = CMD;
            CMD: begin
               if (decode_now) begin
                  case (op_dec)
                     OP_RDSR, OP_RDID: state_nxt = DOUT;
                     OP_READ, OP_PP:   state_nxt = ADDR;
                     OP_NONE:          state_nxt = IGNORE;
                     default:          state_nxt = CMD;
                  endcase
               end
            end
            ADDR: if (sck_rise && bit_cnt == 5'd23) state_nxt = (op == OP_PP) ? DIN : DOUT;
            default: ;
         endcase
      end
   end

   // Commands that act on cs_n rise only count if the frame ended on a byte boundary.
   always_comb begin
      exec_nxt = OP_NONE;
      if (cs_rise) begin
         if (state == CMD && bit_cnt[2:0] == 3'd0 && (op == OP_WREN || op == OP_WRDI || op == OP_BE))
            exec_nxt = op;
         else if (state == DIN && pp_any)
            exec_nxt = OP_PP;
      end
   end

   always_comb begin
      out_byte = 8'h00;
      case (op)
         OP_RDSR: out_byte = {6'b0, wel, wip};
         OP_READ: out_byte = mem_rdata;
         OP_RDID: out_byte = (id_idx == 2'd2) ? 8'h15 : 8'h20;
         default: out_byte = 8'h00;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         op        <= OP_NONE;
         exec_op   <= OP_NONE;
         bit_cnt   <= '0;
         shift_in  <= '0;
         shift_out <= '0;
         addr      <= '0;
         id_idx    <= '0;
         pp_any    <= 1'b0;
         miso_q    <= 1'b0;
      end else begin
         exec_op <= exec_nxt;
         if (cs_rise) begin
            miso_q <= 1'b0;
         end else if (cs_fall && state == IDLE) begin
            op      <= OP_NONE;
            bit_cnt <= '0;
            pp_any  <= 1'b0;
            id_idx  <= '0;
         end else begin
            if (sck_rise && (state == CMD || state == ADDR || state == DIN)) begin
               shift_in <= {shift_in[5:0], mosi_s};
               bit_cnt  <= bit_cnt + 5'd1;
            end
            if (decode_now) op <= op_dec;
            if (state == ADDR && sck_rise) addr <= {addr[MEM_AW-2:0], mosi_s};
            if (pp_wr) begin
               addr   <= addr + MEM_AW'(1);
               pp_any <= 1'b1;
            end
            if (state == DOUT && sck_fall) begin
               bit_cnt <= bit_cnt + 5'd1;
               if (bit_cnt[2:0] == 3'd0) begin
                  miso_q    <= out_byte[7];
                  shift_out <= {out_byte[6:0], 1'b0};
                  if (op == OP_READ) addr <= addr + MEM_AW'(1);
                  if (op == OP_RDID && id_idx != 2'd2) id_idx <= id_idx + 2'd1;
               end else begin
                  miso_q    <= shift_out[7];
                  shift_out <= {shift_out[6:0], 1'b0};
               end
            end
            if (state_nxt != state) bit_cnt <= '0;
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         wel          <= 1'b0;
         busy_cnt     <= '0;
         erase_active <= 1'b0;
         erase_addr   <= '0;
      end else begin
         case (exec_op)
            OP_WREN:      wel <= 1'b1;
            OP_WRDI:      wel <= 1'b0;
            OP_BE, OP_PP: wel <= 1'b0;
            default: ;
         endcase
         if (exec_op == OP_BE)            busy_cnt <= BUSY_W'(ERASE_CYCLES);
         else if (exec_op == OP_PP)       busy_cnt <= BUSY_W'(PROG_CYCLES);
         else if (busy_cnt != '0)         busy_cnt <= busy_cnt - BUSY_W'(1);
         if (exec_op == OP_BE) begin
            erase_active <= 1'b1;
            erase_addr   <= '0;
         end else if (erase_active) begin
            erase_addr <= erase_addr + MEM_AW'(1);
            if (erase_addr == '1) erase_active <= 1'b0;
         end
      end
   end

   // Memory is never reset; a reset mid-erase simply stops the sweep where it was.
   always_ff @(posedge sys_clk) begin
      if (erase_active && !sys_rst) mem[erase_addr] <= 8'hFF;
      else if (pp_wr)               mem[addr] <= mem[addr] & cmd_byte;
      mem_rdata <= mem[addr];
   end
endmodule

// File: tb/tb_spi_flash_resp.sv
// Directed bench for spi_flash_resp: drives SPI mode-0 frames and checks status, memory and timing.
`timescale 1ns/1ps
module tb_spi_flash_resp;
   localparam int HALF = 5;

   logic       sys_clk = 1'b0;
   logic       sys_rst;
   logic       wip, wel;
   logic [7:0] rx;
   int         vectors = 0;
   int         errors  = 0;
   int         n;

   spi_flash_resp_if spi ();

   spi_flash_resp #(.MEM_AW(8), .ERASE_CYCLES(1000), .PROG_CYCLES(50)) dut (
      .sys_clk(sys_clk),
      .sys_rst(sys_rst),
      .spi    (spi.slave),
      .wip    (wip),
      .wel    (wel)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int cnt);
      repeat (cnt) @(posedge sys_clk);
      #1;
   endtask

   task automatic cs_low();
      spi.cs_n = 1'b0;
      tick(HALF);
   endtask

   task automatic cs_high();
      tick(HALF);
      spi.cs_n = 1'b1;
      tick(2*HALF);
   endtask

   // Raise cs_n and count the exact number of cycles wip is high afterwards.
   task automatic cs_high_busy(output int cnt);
      tick(HALF);
      spi.cs_n = 1'b1;
      cnt = 0;
      for (int c = 0; c < 3000; c++) begin
         tick(1);
         if (wip) cnt++;
         else if (cnt > 0) break;
      end
   endtask

   task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] r);
      r = '0;
      for (int i = 0; i < nbits; i++) begin
         spi.mosi = tx[7-i];
         tick(HALF);
         r[7-i]  = spi.miso;
         spi.sck = 1'b1;
         tick(HALF);
         spi.sck = 1'b0;
      end
   endtask

   task automatic cmd_only(input logic [7:0] op);
      logic [7:0] r;
      cs_low();
      xfer(op, 8, r);
      cs_high();
   endtask

   task automatic cmd_addr(input logic [7:0] op, input logic [23:0] a);
      logic [7:0] r;
      cs_low();
      xfer(op, 8, r);
      xfer(a[23:16], 8, r);
      xfer(a[15:8], 8, r);
      xfer(a[7:0], 8, r);
   endtask

   initial begin
      spi.sck  = 1'b0;
      spi.cs_n = 1'b1;
      spi.mosi = 1'b0;
      sys_rst  = 1'b1;
      tick(3);
      sys_rst = 1'b0;
      tick(2);
      chk("reset_wip", wip, 0);
      chk("reset_wel", wel, 0);
      chk("reset_miso", spi.miso, 0);

      cs_low(); xfer(8'h05, 8, rx);
      xfer(8'h00, 8, rx); chk("rdsr_idle0", rx, 8'h00);
      xfer(8'h00, 8, rx); chk("rdsr_idle1", rx, 8'h00);
      cs_high();

      cmd_only(8'h06);
      chk("wren_wel", wel, 1);
      cs_low(); xfer(8'h05, 8, rx); xfer(8'h00, 8, rx); cs_high();
      chk("rdsr_wel", rx, 8'h02);

      cmd_only(8'h04);
      chk("wrdi_wel", wel, 0);
      cs_low(); xfer(8'h06, 7, rx); cs_high();
      chk("wren7_wel", wel, 0);

      cmd_only(8'hC7);
      chk("be_nowel_wip", wip, 0);

      cmd_only(8'h06);
      cs_low(); xfer(8'hC7, 8, rx); cs_high_busy(n);
      chk("be_wip_cycles", n, 1000);
      chk("be_wel", wel, 0);

      cmd_addr(8'h03, 24'h000000);
      for (int i = 0; i < 257; i++) begin
         xfer(8'h00, 8, rx);
         chk($sformatf("erased_%0d", i), rx, 8'hFF);
      end
      cs_high();

      cmd_only(8'h06);
      cmd_addr(8'h02, 24'h0000FE);
      xfer(8'hA5, 8, rx); xfer(8'h3C, 8, rx); xfer(8'h81, 8, rx);
      cs_high_busy(n);
      chk("pp_wip_cycles", n, 50);
      chk("pp_wel", wel, 0);

      cmd_addr(8'h03, 24'h0000FE);
      xfer(8'h00, 8, rx); chk("rd_fe", rx, 8'hA5);
      xfer(8'h00, 8, rx); chk("rd_ff", rx, 8'h3C);
      xfer(8'h00, 8, rx); chk("rd_00_wrap", rx, 8'h81);
      cs_high();

      cmd_only(8'h06);
      cmd_addr(8'h02, 24'h0000FE);
      xfer(8'hF0, 8, rx);
      cs_high_busy(n);
      chk("pp2_wip_cycles", n, 50);
      cmd_addr(8'h03, 24'h0000FE);
      xfer(8'h00, 8, rx); chk("rd_and", rx, 8'hA0);
      cs_high();

      cmd_addr(8'h02, 24'h0000FF);
      xfer(8'h00, 8, rx);
      cs_high();
      chk("pp_nowel_wip", wip, 0);
      cmd_addr(8'h03, 24'h0000FF);
      xfer(8'h00, 8, rx); chk("pp_nowel_keep", rx, 8'h3C);
      cs_high();

      cmd_only(8'h06);
      cmd_addr(8'h02, 24'h0000FF);
      cs_high();
      chk("pp_empty_wip", wip, 0);
      chk("pp_empty_wel", wel, 1);

      cmd_only(8'hC7);
      chk("be2_wip", wip, 1);
      chk("be2_wel", wel, 0);
      cs_low(); xfer(8'h05, 8, rx);
      xfer(8'h00, 8, rx); chk("rdsr_busy_first", rx, 8'h01);
      for (int i = 1; i < 16; i++) xfer(8'h00, 8, rx);
      chk("rdsr_busy_last", rx, 8'h00);
      cs_high();

      cmd_only(8'h06);
      cmd_only(8'hC7);
      cmd_addr(8'h03, 24'h000000);
      xfer(8'h00, 8, rx); chk("rd_busy0", rx, 8'h00);
      xfer(8'h00, 8, rx); chk("rd_busy1", rx, 8'h00);
      cs_high();
      chk("busy_before_rst", wip, 1);
      sys_rst = 1'b1;
      tick(1);
      sys_rst = 1'b0;
      chk("rst_mid_wip", wip, 0);
      chk("rst_mid_wel", wel, 0);
      chk("rst_mid_miso", spi.miso, 0);
      cs_low(); xfer(8'h05, 8, rx); xfer(8'h00, 8, rx); cs_high();
      chk("rdsr_after_rst", rx, 8'h00);

      cs_low(); xfer(8'h9F, 8, rx);
`ifdef FLASH_RESP_RDID_EN
      xfer(8'h00, 8, rx); chk("rdid0", rx, 8'h20);
      xfer(8'h00, 8, rx); chk("rdid1", rx, 8'h20);
      xfer(8'h00, 8, rx); chk("rdid2", rx, 8'h15);
      xfer(8'h00, 8, rx); chk("rdid3", rx, 8'h15);
`else
      xfer(8'h00, 8, rx); chk("rdid_off0", rx, 8'h00);
      xfer(8'h00, 8, rx); chk("rdid_off1", rx, 8'h00);
`endif
      cs_high();

      cs_low(); xfer(8'hAB, 8, rx); xfer(8'h00, 8, rx); cs_high();
      chk("unknown_op", rx, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
